// File: rtl/present_round_engine_pkg.sv
// Shared constants, FSM encoding and the PRESENT substitution layer.
package present_round_engine_pkg;

   localparam int unsigned BLOCK_W = 64;

`ifdef KEY_128
   localparam int unsigned KEY_SIZE = 128;
`else
   localparam int unsigned KEY_SIZE = 80;
`endif

   localparam int unsigned ROUND_COUNT = 31;

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      FINAL
   } fsm_t;

   // 4-bit PRESENT S-box
   function automatic logic [3:0] sbox4(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         default: y = 4'h2;
      endcase
      return y;
   endfunction

   // sixteen S-boxes in parallel, one per nibble
   function automatic logic [BLOCK_W-1:0] s_layer(input logic [BLOCK_W-1:0] x);
      logic [BLOCK_W-1:0] y;
      y = '0;
      for (int unsigned i = 0; i < BLOCK_W / 4; i++) begin
         y[4*i +: 4] = sbox4(x[4*i +: 4]);
      end
      return y;
   endfunction

endpackage

// File: rtl/present_round_engine_player.sv
// PRESENT pLayer: pure wiring permutation, bit i -> bit (16*i) mod 63, bit 63 fixed.
module present_player
   import present_round_engine_pkg::*;
(
   input  logic [BLOCK_W-1:0] blk,
   output logic [BLOCK_W-1:0] perm
);

   // scatter each input bit to its permuted position
   always_comb begin
      perm = '0;
      for (int unsigned i = 0; i < BLOCK_W - 1; i++) begin
         perm[(16 * i) % (BLOCK_W - 1)] = blk[i];
      end
      perm[BLOCK_W-1] = blk[BLOCK_W-1];
   end

endmodule

// File: rtl/present_round_engine.sv
// Iterative PRESENT-64 round engine: one round per clock, round key supplied
// externally for the index driven on round_idx, final whitening to ciphertext.
module present_round_engine
   import present_round_engine_pkg::*;
#(
   parameter int unsigned KEY_W      = KEY_SIZE,
   parameter int unsigned NUM_ROUNDS = ROUND_COUNT
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [BLOCK_W-1:0] plaintext,
   input  logic [KEY_W-1:0]   round_key,
   output logic [4:0]         round_idx,
   output logic               ready,
   output logic               busy,
   output logic [BLOCK_W-1:0] ciphertext,
   output logic               done
);

   localparam logic [4:0] IDX_LAST = 5'(NUM_ROUNDS - 1);

   fsm_t               fsm;
   logic [BLOCK_W-1:0] state;
   logic [BLOCK_W-1:0] rk;
   logic [BLOCK_W-1:0] mixed;
   logic [BLOCK_W-1:0] sboxed;
   logic [BLOCK_W-1:0] permuted;
   logic               unused_key_bits;

   // only the top 64 bits of the key register form the round key
   assign rk              = round_key[KEY_W-1 -: BLOCK_W];
   assign unused_key_bits = ^round_key[KEY_W-BLOCK_W-1:0];

   assign mixed  = state ^ rk;
   assign sboxed = s_layer(mixed);

   present_player u_player (
      .blk  (sboxed),
      .perm (permuted)
   );

   assign ready = (fsm == IDLE);
   assign busy  = ~ready;

   // control FSM and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm        <= IDLE;
         state      <= '0;
         round_idx  <= '0;
         ciphertext <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (fsm)
            IDLE: begin
               if (start) begin
                  state     <= plaintext;
                  round_idx <= '0;
                  fsm       <= ROUND;
               end
            end
            ROUND: begin
               state     <= permuted;
               round_idx <= round_idx + 5'd1;
               if (round_idx == IDX_LAST) begin
                  fsm <= FINAL;
               end
            end
            FINAL: begin
               ciphertext <= mixed;
               done       <= 1'b1;
               round_idx  <= '0;
               fsm        <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/present_round_engine.md
Name: present_round_engine

Overview:
Iterative PRESENT-64 encryption datapath, downstream of the round-key scheduler. It consumes one round key per cycle and runs one full round per clock: addRoundKey, sLayer, pLayer. The current key index is driven out so the scheduler/key store can present the matching round key. The final key whitening produces the ciphertext, with a start/done handshake.

Parameters:
BLOCK_W, 64, cipher state width (fixed by PRESENT; not to be overridden)
KEY_W, `key_size (80, or 128 under KEY_128), round-key register width
NUM_ROUNDS, `num_rounds (31), full S/P rounds before final key addition

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-high
start  in  1  request encryption; sampled only when ready=1
plaintext  in  BLOCK_W  input block, sampled on accepting edge
round_key  in  KEY_W  key register for index round_idx, valid combinationally same cycle
round_idx  out  5  index of round key consumed this cycle (0..NUM_ROUNDS)
ready  out  1  engine idle, start will be accepted
busy  out  1  ~ready
ciphertext  out  BLOCK_W  result; held until next accepted start
done  out  1  one-cycle pulse, ciphertext valid

Behaviour:
- Reset (async assert, sync deassert by usage): FSM=IDLE, state=0, round_idx=0, ciphertext=0, done=0, ready=1.
- Round key used = round_key[KEY_W-1 -: 64] (top 64 bits).
- FSM IDLE: ready=1. On edge with start=1: state<=plaintext, round_idx<=0, ->ROUND. Start with ready=0 is ignored (no queue).
- ROUND: each edge: state<=P(S(state ^ rk)); round_idx<=round_idx+1. At edge where round_idx==NUM_ROUNDS-1 -> FINAL (round_idx becomes NUM_ROUNDS).
- FINAL: edge: ciphertext<=state ^ rk; done<=1; round_idx<=0; ->IDLE.
- done is high for exactly the one cycle after the FINAL edge; ready returns high in that same cycle. A start in that cycle is accepted (back-to-back, ciphertext held while new run proceeds).
- Latency: accepting edge E0; rounds E1..E31; final E32; done visible after E32 (32 cycles start-edge to done). Throughput: one block per 32 cycles.
- sLayer: 16 parallel 4-bit PRESENT S-boxes on nibbles [4i+3:4i].
- pLayer: bit i -> bit (16*i) mod 63 for i<63; bit 63 -> 63.
- round_idx never exceeds NUM_ROUNDS; no wrap.
- plaintext changes after E0 have no effect.
- rst mid-operation: immediate abort to reset values; no done pulse; partial state discarded.
- round_idx is registered (no combinational path from start to round_idx).

Decomposition:
- Shared package / Constants.sv: BLOCK_W, existing `key_size, `num_rounds, KEY_128 switch, FSM state enum {IDLE, ROUND, FINAL}.
- Reuse existing 4-bit SBox module, 16 instances.
- One new sub-module: present_player (pure combinational 64-bit bit permutation), verified separately.

Test Plan:
- KEY_W=80, key=0, plaintext=0x0000000000000000 -> ciphertext 0x5579C1387B228445, done exactly 32 cycles after start edge. Bench drives round_key from a golden scheduler model indexed by round_idx.
- key=0xFFFF..FF (80b), pt=0 -> 0xE72C46C0F5945049; pt=0xFFFFFFFFFFFFFFFF, key=0 -> 0xA112FFC72F68417B; both all-ones -> 0x3333DCD3213210D2.
- Start held high continuously with two plaintexts -> second accepted in done cycle, round_idx sequence 0..31 then 0 again, both ciphertexts correct.
- Start pulsed while busy at round_idx=10 -> ignored, result unchanged, no extra done.
- rst asserted at round_idx=15 (async, mid-cycle) -> outputs zero immediately, ready=1, no done; a fresh run afterward is correct.
- present_player unit check: single-hot inputs bit 1 -> bit 16, bit 62 -> bit 47, bit 63 -> bit 63.
